// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DATA   = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that did not win last time.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       winner_o,
  output logic       valid_o
);

  // Pick a winner from the current request vector.
  always_comb begin
    valid_o  = |req_i;
    winner_o = PORT_IF;
    unique case (req_i)
      2'b01:   winner_o = PORT_IF;
      2'b10:   winner_o = PORT_LS;
      2'b11:   winner_o = ~last_grant_i;
      default: winner_o = PORT_IF;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port memory between instruction fetch (port 0) and
// load/store (port 1). One transaction in flight; all outputs registered.
// Because outputs are registered, each visible effect trails the FSM state
// that produced it by one cycle: gnt shows while in ACCESS, the strobes show
// while in DATA/RESP, and done/rdata show in the following IDLE cycle.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] Adr,
  output logic [DATA_W-1:0] MWD,
  output logic              MWR,
  output logic              MOE,
  input  logic [DATA_W-1:0] MRD
);

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic                port_q, port_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          gnt_q, gnt_d;
  logic [1:0]          done_q, done_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [DATA_W-1:0]   mwd_q, mwd_d;
  logic                mwr_q, mwr_d;
  logic                moe_q, moe_d;

  logic                arb_win;
  logic                arb_vld;

  rr_arb2 u_arb (
    .req_i        (req),
    .last_grant_i (last_q),
    .winner_o     (arb_win),
    .valid_o      (arb_vld)
  );

  // Next-state and registered-output logic; strobes/pulses default low.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    port_d  = port_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    gnt_d   = 2'b00;
    done_d  = 2'b00;
    rdata_d = rdata_q;
    adr_d   = adr_q;
    mwd_d   = mwd_q;
    mwr_d   = 1'b0;
    moe_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_vld) begin
          port_d         = arb_win;
          last_d         = arb_win;
          we_d           = we[arb_win];
          addr_d         = arb_win ? addr1 : addr0;
          wdata_d        = arb_win ? wdata1 : wdata0;
          gnt_d[arb_win] = 1'b1;
          state_d        = ACCESS;
        end
      end
      ACCESS: begin
        adr_d = addr_q;
        if (we_q) begin
          mwr_d   = 1'b1;
          mwd_d   = wdata_q;
          state_d = RESP;
        end else begin
          moe_d   = 1'b1;
          state_d = DATA;
        end
      end
      // Memory samples Adr/MOE here; its MRD arrives in the next cycle.
      DATA: state_d = RESP;
      RESP: begin
        done_d[port_q] = 1'b1;
        if (!we_q) rdata_d = MRD;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= PORT_LS;
      port_q  <= PORT_IF;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      rdata_q <= '0;
      adr_q   <= '0;
      mwd_q   <= '0;
      mwr_q   <= 1'b0;
      moe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      port_q  <= port_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      adr_q   <= adr_d;
      mwd_q   <= mwd_d;
      mwr_q   <= mwr_d;
      moe_q   <= moe_d;
    end
  end

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign rdata = rdata_q;
  assign busy  = (state_q != IDLE);
  assign Adr   = adr_q;
  assign MWD   = mwd_q;
  assign MWR   = mwr_q;
  assign MOE   = moe_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a registered-read memory model.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req, we;
  logic [8:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic [1:0]  gnt, done;
  logic [31:0] rdata;
  logic        busy;
  logic [8:0]  Adr;
  logic [31:0] MWD;
  logic        MWR, MOE;
  logic [31:0] MRD;

  int nchk = 0;
  int nerr = 0;

  logic [31:0] mem [512] = '{default: '0};

  mem_port_arbiter #(.ADDR_W(9), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
    .Adr(Adr), .MWD(MWD), .MWR(MWR), .MOE(MOE), .MRD(MRD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory: write on MWR, registered read one cycle after MOE.
  always @(posedge clk) begin
    if (MWR) mem[Adr] <= MWD;
    if (MOE) MRD <= mem[Adr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req = 2'b00;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req = 2'b00; we = 2'b00; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (2) tick();
    nchk++; if (gnt !== 2'b00) begin nerr++; $display("FAIL rst_gnt got %b exp 00", gnt); end
    nchk++; if (done !== 2'b00) begin nerr++; $display("FAIL rst_done got %b exp 00", done); end
    nchk++; if (MWR !== 1'b0) begin nerr++; $display("FAIL rst_mwr got %b exp 0", MWR); end
    nchk++; if (MOE !== 1'b0) begin nerr++; $display("FAIL rst_moe got %b exp 0", MOE); end
    nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_busy got %b exp 0", busy); end
    nchk++; if (rdata !== 32'h0) begin nerr++; $display("FAIL rst_rdata got %h exp 0", rdata); end
    nchk++; if (Adr !== 9'h0) begin nerr++; $display("FAIL rst_adr got %h exp 0", Adr); end
    nchk++; if (MWD !== 32'h0) begin nerr++; $display("FAIL rst_mwd got %h exp 0", MWD); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ls_write;
    req = 2'b10; we = 2'b10; addr1 = 9'd10; wdata1 = 32'h1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) begin
        nchk++; if (gnt !== 2'b10) begin nerr++; $display("FAIL wr_gnt got %b exp 10", gnt); end
        nchk++; if (busy !== 1'b1) begin nerr++; $display("FAIL wr_busy got %b exp 1", busy); end
        req = 2'b00;
      end
      if (c == 2) begin
        nchk++; if (MWR !== 1'b1) begin nerr++; $display("FAIL wr_mwr got %b exp 1", MWR); end
        nchk++; if (Adr !== 9'd10) begin nerr++; $display("FAIL wr_adr got %0d exp 10", Adr); end
        nchk++; if (MWD !== 32'h1) begin nerr++; $display("FAIL wr_mwd got %h exp 1", MWD); end
        nchk++; if (MOE !== 1'b0) begin nerr++; $display("FAIL wr_moe got %b exp 0", MOE); end
      end
      if (c == 3) begin
        nchk++; if (done !== 2'b10) begin nerr++; $display("FAIL wr_done got %b exp 10", done); end
        nchk++; if (MWR !== 1'b0) begin nerr++; $display("FAIL wr_mwr_off got %b exp 0", MWR); end
      end
    end
  endtask

  task automatic test_if_read;
    int moe_cnt;
    moe_cnt = 0;
    req = 2'b01; we = 2'b00; addr0 = 9'd10;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (MOE) moe_cnt++;
      if (c == 1) begin
        nchk++; if (gnt !== 2'b01) begin nerr++; $display("FAIL rd_gnt got %b exp 01", gnt); end
        req = 2'b00;
      end
      if (c == 2) begin
        nchk++; if (MOE !== 1'b1) begin nerr++; $display("FAIL rd_moe got %b exp 1", MOE); end
        nchk++; if (Adr !== 9'd10) begin nerr++; $display("FAIL rd_adr got %0d exp 10", Adr); end
      end
      if (c == 3) begin
        nchk++; if (done !== 2'b00) begin nerr++; $display("FAIL rd_done_early got %b exp 00", done); end
      end
      if (c == 4) begin
        nchk++; if (done !== 2'b01) begin nerr++; $display("FAIL rd_done got %b exp 01", done); end
        nchk++; if (rdata !== 32'h1) begin nerr++; $display("FAIL rd_rdata got %h exp 1", rdata); end
      end
    end
    nchk++; if (moe_cnt != 1) begin nerr++; $display("FAIL rd_moe_cycles got %0d exp 1", moe_cnt); end
  endtask

  task automatic test_tie_after_reset;
    do_reset();
    req = 2'b11; we = 2'b10; addr0 = 9'd0; addr1 = 9'd0; wdata1 = 32'hA5;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) begin
        nchk++; if (gnt !== 2'b01) begin nerr++; $display("FAIL tie_gnt1 got %b exp 01", gnt); end
      end
      if (c == 4) begin
        nchk++; if (done !== 2'b01) begin nerr++; $display("FAIL tie_done0 got %b exp 01", done); end
        nchk++; if (rdata !== 32'h0) begin nerr++; $display("FAIL tie_rdata got %h exp 0", rdata); end
      end
      if (c == 5) begin
        nchk++; if (gnt !== 2'b10) begin nerr++; $display("FAIL tie_gnt2 got %b exp 10", gnt); end
      end
      if (c == 7) begin
        nchk++; if (done !== 2'b10) begin nerr++; $display("FAIL tie_done1 got %b exp 10", done); end
      end
      if (gnt[0]) req[0] = 1'b0;
      if (gnt[1]) req[1] = 1'b0;
    end
    // Read back the word LS just wrote.
    req = 2'b01; we = 2'b00; addr0 = 9'd0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) req = 2'b00;
      if (c == 4) begin
        nchk++; if (rdata !== 32'hA5) begin nerr++; $display("FAIL tie_readback got %h exp a5", rdata); end
      end
    end
  endtask

  task automatic test_fairness;
    logic [1:0] order [6];
    int ng, nd, bad;
    ng = 0; nd = 0; bad = 0;
    do_reset();
    req = 2'b11; we = 2'b10; addr0 = 9'd20; addr1 = 9'd20; wdata1 = 32'h77;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (gnt == 2'b11 || done == 2'b11 || (MWR && MOE)) bad++;
      if (done != 2'b00) nd++;
      if (gnt != 2'b00) begin
        if (ng < 6) order[ng] = gnt;
        ng++;
        if (ng == 6) req = 2'b00;
      end
    end
    nchk++; if (ng != 6) begin nerr++; $display("FAIL fair_gnt_count got %0d exp 6", ng); end
    nchk++; if (nd != 6) begin nerr++; $display("FAIL fair_done_count got %0d exp 6", nd); end
    nchk++; if (bad != 0) begin nerr++; $display("FAIL fair_overlap got %0d exp 0", bad); end
    for (int k = 0; k < 6 && k < ng; k++) begin
      logic [1:0] exp_g;
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      nchk++;
      if (order[k] !== exp_g) begin
        nerr++; $display("FAIL fair_order[%0d] got %b exp %b", k, order[k], exp_g);
      end
    end
  endtask

  task automatic test_hold_off;
    int done0_cyc, gnt1_cyc, mwr_early;
    done0_cyc = 0; gnt1_cyc = 0; mwr_early = 0;
    req = 2'b01; we = 2'b00; addr0 = 9'd10;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) begin
        nchk++; if (gnt !== 2'b01) begin nerr++; $display("FAIL hold_gnt0 got %b exp 01", gnt); end
        req = 2'b10; we = 2'b10; addr1 = 9'd30; wdata1 = 32'h5;
      end
      if (done[0] && done0_cyc == 0) done0_cyc = c;
      if (gnt[1] && gnt1_cyc == 0) gnt1_cyc = c;
      if (c <= 4 && MWR) mwr_early++;
      if (c == 6) begin
        nchk++; if (MWR !== 1'b1) begin nerr++; $display("FAIL hold_mwr got %b exp 1", MWR); end
        nchk++; if (Adr !== 9'd30) begin nerr++; $display("FAIL hold_adr got %0d exp 30", Adr); end
      end
      if (gnt[1]) req = 2'b00;
    end
    nchk++; if (done0_cyc != 4) begin nerr++; $display("FAIL hold_done0_cycle got %0d exp 4", done0_cyc); end
    nchk++; if (gnt1_cyc != 5) begin nerr++; $display("FAIL hold_gnt1_cycle got %0d exp 5", gnt1_cyc); end
    nchk++; if (mwr_early != 0) begin nerr++; $display("FAIL hold_mwr_early got %0d exp 0", mwr_early); end
  endtask

  task automatic test_reset_mid;
    int ndone;
    ndone = 0;
    req = 2'b01; we = 2'b00; addr0 = 9'd10;
    tick();
    nchk++; if (gnt !== 2'b01) begin nerr++; $display("FAIL mid_gnt got %b exp 01", gnt); end
    req = 2'b00;
    tick();
    nchk++; if (MOE !== 1'b1) begin nerr++; $display("FAIL mid_moe_pre got %b exp 1", MOE); end
    rst_n = 1'b0;
    #1;
    nchk++; if (MOE !== 1'b0) begin nerr++; $display("FAIL mid_moe got %b exp 0", MOE); end
    nchk++; if (MWR !== 1'b0) begin nerr++; $display("FAIL mid_mwr got %b exp 0", MWR); end
    nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL mid_busy got %b exp 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (done != 2'b00) ndone++;
    end
    nchk++; if (ndone != 0) begin nerr++; $display("FAIL mid_no_done got %0d exp 0", ndone); end
    req = 2'b11; we = 2'b00; addr0 = 9'd10; addr1 = 9'd10;
    tick();
    nchk++; if (gnt !== 2'b01) begin nerr++; $display("FAIL mid_tie_gnt got %b exp 01", gnt); end
    req = 2'b00;
    repeat (5) tick();
  endtask

  initial begin
    test_reset();
    test_ls_write();
    test_if_read();
    test_tie_after_reset();
    test_fairness();
    test_hold_off();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
